// File: rtl/mouse_position_tracker.sv
// rtl/mouse_position_tracker.sv - PS/2 packet to clamped/wrapped X/Y/Z position accumulator
module mouse_position_tracker #(
  parameter int COORD_W    = 10,
  parameter int LIMIT_X    = 640,
  parameter int LIMIT_Y    = 480,
  parameter int LIMIT_Z    = 256,
  parameter int MODE_X     = 0,
  parameter int MODE_Y     = 0,
  parameter int MODE_Z     = 1,
  parameter int SENS_SHIFT = 0,
  parameter int INVERT_Y   = 0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               PKT_VALID,
  output logic               PKT_READY,
  input  logic [7:0]         STATUS_RAW,
  input  logic [7:0]         DX_RAW,
  input  logic [7:0]         DY_RAW,
  input  logic [7:0]         DZ_RAW,
  input  logic               CENTRE,
  output logic [3:0]         MOUSE_STATUS,
  output logic [COORD_W-1:0] MOUSE_X,
  output logic [COORD_W-1:0] MOUSE_Y,
  output logic [COORD_W-1:0] MOUSE_Z,
  output logic               POS_UPDATED
);

  // Deltas live in a signed word wide enough for a shifted 9-bit delta
  // plus a position, so the sum never truncates.
  localparam int DW = COORD_W + 6;
  typedef logic signed [DW-1:0] delta_t;

  localparam delta_t LIM_X    = delta_t'(LIMIT_X);
  localparam delta_t LIM_Y    = delta_t'(LIMIT_Y);
  localparam delta_t LIM_Z    = delta_t'(LIMIT_Z);
  localparam delta_t LIM_X_M1 = delta_t'(LIMIT_X - 1);
  localparam delta_t LIM_Y_M1 = delta_t'(LIMIT_Y - 1);
  localparam delta_t LIM_Z_M1 = delta_t'(LIMIT_Z - 1);

  localparam logic [COORD_W-1:0] HALF_X = COORD_W'(LIMIT_X / 2);
  localparam logic [COORD_W-1:0] HALF_Y = COORD_W'(LIMIT_Y / 2);
  localparam logic [COORD_W-1:0] HALF_Z = COORD_W'(LIMIT_Z / 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    UPD  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [7:0]         st_raw_q, dx_raw_q, dy_raw_q, dz_raw_q;
  delta_t             dx_q, dy_q, dz_q;
  logic [COORD_W-1:0] x_q, y_q, z_q;
  logic [3:0]         status_q;
  logic               upd_q;

  // Overflow forces full-scale magnitude; otherwise the sign bit extends the
  // low byte to 9 bits. Negation happens in the wide word so -(-256) fits.
  function automatic delta_t make_delta(input logic ovf, input logic sign,
                                        input logic [7:0] raw, input logic neg);
    logic signed [8:0] d9;
    delta_t            w;
    if (ovf) d9 = sign ? 9'sh100 : 9'sh0FF;
    else     d9 = {sign, raw};
    w = {{(DW-9){d9[8]}}, d9};
    if (neg) w = -w;
    return w <<< SENS_SHIFT;
  endfunction

  // One axis update; wrap mode pre-saturates the delta so a single
  // +/-LIMIT correction always lands back in range.
  function automatic logic [COORD_W-1:0] step_axis(input logic [COORD_W-1:0] pos,
                                                   input delta_t delta,
                                                   input delta_t lim,
                                                   input delta_t lim_m1,
                                                   input logic wrap);
    delta_t d, n;
    d = delta;
    if (wrap) begin
      if (d > lim_m1)        d = lim_m1;
      else if (d < -lim_m1)  d = -lim_m1;
    end
    n = $signed({{(DW-COORD_W){1'b0}}, pos}) + d;
    if (wrap) begin
      if (n[DW-1])         n = n + lim;
      else if (n > lim_m1) n = n - lim;
    end else begin
      if (n[DW-1])         n = '0;
      else if (n > lim_m1) n = lim_m1;
    end
    return n[COORD_W-1:0];
  endfunction

  assign PKT_READY = (state_q == IDLE) && !CENTRE;

  // State register; reset and recentre both return to IDLE.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: accept, extract, commit, back to idle.
  always_comb begin
    state_d = state_q;
    if (CENTRE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (PKT_VALID) state_d = EXT;
        EXT:     state_d = UPD;
        UPD:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: capture raw bytes, form deltas, then commit all three axes.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st_raw_q <= '0;
      dx_raw_q <= '0;
      dy_raw_q <= '0;
      dz_raw_q <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      dz_q     <= '0;
      x_q      <= HALF_X;
      y_q      <= HALF_Y;
      z_q      <= HALF_Z;
      status_q <= '0;
      upd_q    <= 1'b0;
    end else if (CENTRE) begin
      x_q   <= HALF_X;
      y_q   <= HALF_Y;
      z_q   <= HALF_Z;
      upd_q <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (PKT_VALID) begin
            st_raw_q <= STATUS_RAW;
            dx_raw_q <= DX_RAW;
            dy_raw_q <= DY_RAW;
            dz_raw_q <= DZ_RAW;
          end
        end
        EXT: begin
          dx_q <= make_delta(st_raw_q[6], st_raw_q[4], dx_raw_q, 1'b0);
          dy_q <= make_delta(st_raw_q[7], st_raw_q[5], dy_raw_q, INVERT_Y != 0);
          dz_q <= make_delta(1'b0, dz_raw_q[7], dz_raw_q, 1'b0);
        end
        UPD: begin
          x_q      <= step_axis(x_q, dx_q, LIM_X, LIM_X_M1, MODE_X != 0);
          y_q      <= step_axis(y_q, dy_q, LIM_Y, LIM_Y_M1, MODE_Y != 0);
          z_q      <= step_axis(z_q, dz_q, LIM_Z, LIM_Z_M1, MODE_Z != 0);
          status_q <= st_raw_q[3:0];
          upd_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign MOUSE_X      = x_q;
  assign MOUSE_Y      = y_q;
  assign MOUSE_Z      = z_q;
  assign MOUSE_STATUS = status_q;
  assign POS_UPDATED  = upd_q;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// tb/tb_mouse_position_tracker.sv - bench for mouse_position_tracker, default and variant builds
module tb_mouse_position_tracker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pkt_valid = 1'b0;
  logic       centre = 1'b0;
  logic [7:0] st_raw = '0, dx_raw = '0, dy_raw = '0, dz_raw = '0;

  logic       a_rdy, b_rdy, a_upd, b_upd;
  logic [3:0] a_st, b_st;
  logic [9:0] a_x, a_y, a_z, b_x, b_y, b_z;

  int total = 0;
  int bad = 0;

  // Reference positions per instance (0 = defaults, 1 = variant).
  int mx[2], my[2], mz[2], ms[2];
  int sh[2]   = '{0, 2};
  int inv[2]  = '{0, 1};
  int wrpx[2] = '{0, 1};

  always #5 clk = ~clk;

  mouse_position_tracker dut_a (
    .CLK(clk), .RESET(reset), .PKT_VALID(pkt_valid), .PKT_READY(a_rdy),
    .STATUS_RAW(st_raw), .DX_RAW(dx_raw), .DY_RAW(dy_raw), .DZ_RAW(dz_raw),
    .CENTRE(centre), .MOUSE_STATUS(a_st), .MOUSE_X(a_x), .MOUSE_Y(a_y),
    .MOUSE_Z(a_z), .POS_UPDATED(a_upd)
  );

  mouse_position_tracker #(.SENS_SHIFT(2), .INVERT_Y(1), .MODE_X(1)) dut_b (
    .CLK(clk), .RESET(reset), .PKT_VALID(pkt_valid), .PKT_READY(b_rdy),
    .STATUS_RAW(st_raw), .DX_RAW(dx_raw), .DY_RAW(dy_raw), .DZ_RAW(dz_raw),
    .CENTRE(centre), .MOUSE_STATUS(b_st), .MOUSE_X(b_x), .MOUSE_Y(b_y),
    .MOUSE_Z(b_z), .POS_UPDATED(b_upd)
  );

  wire [33:0] a_vec = {a_st, a_x, a_y, a_z};
  wire [33:0] b_vec = {b_st, b_x, b_y, b_z};

  function automatic logic [33:0] exp_vec(input int i);
    return {4'(ms[i]), 10'(mx[i]), 10'(my[i]), 10'(mz[i])};
  endfunction

  function automatic int raw_delta(input bit ovf, input bit sign, input int raw);
    if (ovf) return sign ? -256 : 255;
    return sign ? raw - 256 : raw;
  endfunction

  function automatic int axis(input int pos, input int d, input int lim, input int wrap);
    int dd, n;
    if (wrap != 0) begin
      dd = (d > lim - 1) ? lim - 1 : (d < -(lim - 1)) ? -(lim - 1) : d;
      return ((pos + dd) % lim + lim) % lim;
    end
    n = pos + d;
    if (n < 0) return 0;
    if (n > lim - 1) return lim - 1;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = 320; my[i] = 240; mz[i] = 128; ms[i] = 0;
    end
  endtask

  task automatic model_centre();
    for (int i = 0; i < 2; i++) begin
      mx[i] = 320; my[i] = 240; mz[i] = 128;
    end
  endtask

  task automatic model_pkt(input logic [7:0] st, input logic [7:0] dx,
                           input logic [7:0] dy, input logic [7:0] dz);
    int ddx, ddy, ddz;
    for (int i = 0; i < 2; i++) begin
      ddx = raw_delta(st[6], st[4], int'(dx)) * (1 << sh[i]);
      ddy = raw_delta(st[7], st[5], int'(dy));
      if (inv[i] != 0) ddy = -ddy;
      ddy = ddy * (1 << sh[i]);
      ddz = ((int'(dz) >= 128) ? int'(dz) - 256 : int'(dz)) * (1 << sh[i]);
      mx[i] = axis(mx[i], ddx, 640, wrpx[i]);
      my[i] = axis(my[i], ddy, 480, 0);
      mz[i] = axis(mz[i], ddz, 256, 1);
      ms[i] = int'(st[3:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one packet from IDLE and returns just after its commit edge.
  task automatic send_pkt(input logic [7:0] st, input logic [7:0] dx,
                          input logic [7:0] dy, input logic [7:0] dz);
    st_raw = st; dx_raw = dx; dy_raw = dy; dz_raw = dz;
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    tick();
    tick();
    model_pkt(st, dx, dy, dz);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (a_vec !== {4'd0, 10'd320, 10'd240, 10'd128}) begin
      bad++; $display("FAIL reset_a got %h want %h", a_vec, {4'd0, 10'd320, 10'd240, 10'd128});
    end
    total++;
    if (b_vec !== exp_vec(1)) begin
      bad++; $display("FAIL reset_b got %h want %h", b_vec, exp_vec(1));
    end
    total++;
    if ({a_rdy, a_upd, b_rdy, b_upd} !== 4'b1010) begin
      bad++; $display("FAIL reset_flags got %b want 1010", {a_rdy, a_upd, b_rdy, b_upd});
    end
  endtask

  task automatic test_basic_back_to_back();
    st_raw = 8'h29; dx_raw = 8'h10; dy_raw = 8'hF0; dz_raw = 8'h01;
    pkt_valid = 1'b1;
    tick();                                  // edge k
    st_raw = 8'h02; dx_raw = 8'h05; dy_raw = 8'h03; dz_raw = 8'hFF;
    total++;
    if ({a_rdy, a_upd} !== 2'b00) begin
      bad++; $display("FAIL basic_k got rdy,upd=%b want 00", {a_rdy, a_upd});
    end
    tick();                                  // edge k+1
    total++;
    if ({a_rdy, a_upd} !== 2'b00) begin
      bad++; $display("FAIL basic_k1 got rdy,upd=%b want 00", {a_rdy, a_upd});
    end
    tick();                                  // edge k+2
    model_pkt(8'h29, 8'h10, 8'hF0, 8'h01);
    total++;
    if (a_upd !== 1'b1 || a_vec !== {4'h9, 10'd336, 10'd224, 10'd129}) begin
      bad++; $display("FAIL basic_commit_a got upd=%b %h want 1 %h", a_upd, a_vec, {4'h9, 10'd336, 10'd224, 10'd129});
    end
    total++;
    if (b_upd !== 1'b1 || b_vec !== exp_vec(1)) begin
      bad++; $display("FAIL basic_commit_b got upd=%b %h want 1 %h", b_upd, b_vec, exp_vec(1));
    end
    total++;
    if (a_rdy !== 1'b1) begin
      bad++; $display("FAIL basic_ready_k2 got %b want 1", a_rdy);
    end
    tick();                                  // edge k+3: second packet accepted
    pkt_valid = 1'b0;
    total++;
    if ({a_rdy, a_upd} !== 2'b00) begin
      bad++; $display("FAIL b2b_accept got rdy,upd=%b want 00", {a_rdy, a_upd});
    end
    tick();
    tick();
    model_pkt(8'h02, 8'h05, 8'h03, 8'hFF);
    total++;
    if (a_upd !== 1'b1 || a_vec !== exp_vec(0) || b_vec !== exp_vec(1)) begin
      bad++; $display("FAIL b2b_commit got upd=%b a=%h b=%h want 1 a=%h b=%h", a_upd, a_vec, b_vec, exp_vec(0), exp_vec(1));
    end
    tick();
    total++;
    if (a_upd !== 1'b0) begin
      bad++; $display("FAIL upd_pulse_width got %b want 0", a_upd);
    end
  endtask

  task automatic test_clamp_overflow();
    for (int i = 0; i < 3; i++) send_pkt(8'h48, 8'h00, 8'h00, 8'h00);
    total++;
    if (a_x !== 10'd639 || b_vec !== exp_vec(1)) begin
      bad++; $display("FAIL clamp_x_hi got a_x=%0d b=%h want 639 b=%h", a_x, b_vec, exp_vec(1));
    end
    send_pkt(8'h08, 8'h7F, 8'h00, 8'h00);
    total++;
    if (a_x !== 10'd639 || b_vec !== exp_vec(1)) begin
      bad++; $display("FAIL clamp_x_7f got a_x=%0d b=%h want 639 b=%h", a_x, b_vec, exp_vec(1));
    end
    for (int i = 0; i < 3; i++) send_pkt(8'h58, 8'h00, 8'h00, 8'h00);
    total++;
    if (a_x !== 10'd0 || b_vec !== exp_vec(1)) begin
      bad++; $display("FAIL clamp_x_lo got a_x=%0d b=%h want 0 b=%h", a_x, b_vec, exp_vec(1));
    end
    for (int i = 0; i < 32; i++) send_pkt(8'h28, 8'h00, 8'hF0, 8'h00);
    total++;
    if (a_y !== 10'd0 || b_vec !== exp_vec(1)) begin
      bad++; $display("FAIL clamp_y_lo got a_y=%0d b=%h want 0 b=%h", a_y, b_vec, exp_vec(1));
    end
  endtask

  task automatic test_z_wrap();
    centre = 1'b1;
    tick();
    centre = 1'b0;
    model_centre();
    send_pkt(8'h00, 8'h00, 8'h00, 8'h7A);
    total++;
    if (a_z !== 10'd250) begin
      bad++; $display("FAIL z_setup got %0d want 250", a_z);
    end
    send_pkt(8'h00, 8'h00, 8'h00, 8'h0A);
    total++;
    if (a_z !== 10'd4 || b_vec !== exp_vec(1)) begin
      bad++; $display("FAIL z_wrap_up got a_z=%0d b=%h want 4 b=%h", a_z, b_vec, exp_vec(1));
    end
    send_pkt(8'h00, 8'h00, 8'h00, 8'hFF);
    send_pkt(8'h00, 8'h00, 8'h00, 8'hFB);
    total++;
    if (a_z !== 10'd254 || b_vec !== exp_vec(1)) begin
      bad++; $display("FAIL z_wrap_down got a_z=%0d b=%h want 254 b=%h", a_z, b_vec, exp_vec(1));
    end
  endtask

  task automatic test_random();
    logic [7:0] s, x, y, z;
    for (int i = 0; i < 40; i++) begin
      s = 8'($urandom); x = 8'($urandom); y = 8'($urandom); z = 8'($urandom);
      send_pkt(s, x, y, z);
      total++;
      if (a_vec !== exp_vec(0) || a_upd !== 1'b1) begin
        bad++; $display("FAIL random_a[%0d] got %h upd=%b want %h", i, a_vec, a_upd, exp_vec(0));
      end
      total++;
      if (b_vec !== exp_vec(1) || b_upd !== 1'b1) begin
        bad++; $display("FAIL random_b[%0d] got %h upd=%b want %h", i, b_vec, b_upd, exp_vec(1));
      end
    end
  endtask

  task automatic test_centre_in_ext();
    st_raw = 8'h0F; dx_raw = 8'h40; dy_raw = 8'h40; dz_raw = 8'h20;
    pkt_valid = 1'b1;
    tick();                                  // accepted, now in EXT
    pkt_valid = 1'b0;
    centre = 1'b1;
    tick();
    model_centre();
    total++;
    if (a_vec !== exp_vec(0) || b_vec !== exp_vec(1) || a_upd !== 1'b0) begin
      bad++; $display("FAIL centre_ext got a=%h b=%h upd=%b want a=%h b=%h upd=0", a_vec, b_vec, a_upd, exp_vec(0), exp_vec(1));
    end
    centre = 1'b0;
    #1;
    total++;
    if ({a_rdy, b_rdy} !== 2'b11) begin
      bad++; $display("FAIL centre_ready got %b want 11", {a_rdy, b_rdy});
    end
    tick();
    tick();
    total++;
    if (a_upd !== 1'b0 || b_upd !== 1'b0 || a_vec !== exp_vec(0)) begin
      bad++; $display("FAIL centre_discard got upd=%b a=%h want 0 a=%h", a_upd, a_vec, exp_vec(0));
    end
  endtask

  task automatic test_centre_with_valid();
    send_pkt(8'h03, 8'h11, 8'h22, 8'h05);
    st_raw = 8'h07; dx_raw = 8'h30; dy_raw = 8'h30; dz_raw = 8'h30;
    pkt_valid = 1'b1;
    centre = 1'b1;
    #1;
    total++;
    if ({a_rdy, b_rdy} !== 2'b00) begin
      bad++; $display("FAIL centre_valid_ready got %b want 00", {a_rdy, b_rdy});
    end
    tick();
    pkt_valid = 1'b0;
    centre = 1'b0;
    model_centre();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (a_upd !== 1'b0 || a_vec !== exp_vec(0) || b_vec !== exp_vec(1)) begin
        bad++; $display("FAIL centre_valid[%0d] got upd=%b a=%h b=%h want 0 a=%h b=%h", i, a_upd, a_vec, b_vec, exp_vec(0), exp_vec(1));
      end
      tick();
    end
  endtask

  task automatic test_reset_in_upd();
    send_pkt(8'h05, 8'h21, 8'h12, 8'h03);
    st_raw = 8'h0A; dx_raw = 8'h50; dy_raw = 8'h50; dz_raw = 8'h50;
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    tick();                                  // now in UPD
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    total++;
    if (a_vec !== {4'd0, 10'd320, 10'd240, 10'd128} || b_vec !== exp_vec(1)) begin
      bad++; $display("FAIL reset_upd got a=%h b=%h want a=%h b=%h", a_vec, b_vec, {4'd0, 10'd320, 10'd240, 10'd128}, exp_vec(1));
    end
    total++;
    if ({a_rdy, a_upd, b_rdy, b_upd} !== 4'b1010) begin
      bad++; $display("FAIL reset_upd_flags got %b want 1010", {a_rdy, a_upd, b_rdy, b_upd});
    end
  endtask

  initial begin
    test_reset();
    test_basic_back_to_back();
    test_clamp_overflow();
    test_z_wrap();
    test_random();
    test_centre_in_ext();
    test_centre_with_valid();
    test_reset_in_upd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mouse_position_tracker.md
Name: mouse_position_tracker

Overview:
- Parametrised position accumulator between the mouse master state machine and display/VGA consumers.
- Accepts one raw 4-byte PS/2 packet per valid/ready handshake: status, dx, dy and dz.
- Converts the deltas to signed values, handling overflow and applying sensitivity scaling and optional Y inversion.
- Updates X/Y/Z positions with a per-axis clamp or wrap mode, plus a synchronous recentre command.

Parameters:
- COORD_W, 10, width of each position output; every LIMIT_* must be at most 2^COORD_W.
- LIMIT_X, 640, X range is 0..LIMIT_X-1 (at least 2).
- LIMIT_Y, 480, Y range is 0..LIMIT_Y-1 (at least 2).
- LIMIT_Z, 256, Z range is 0..LIMIT_Z-1 (at least 2).
- MODE_X, 0, X axis mode: 0 = clamp, 1 = wrap.
- MODE_Y, 0, Y axis mode: 0 = clamp, 1 = wrap.
- MODE_Z, 1, Z axis mode: 0 = clamp, 1 = wrap.
- SENS_SHIFT, 0, left shift applied to every delta; legal values 0..3.
- INVERT_Y, 0, when 1, negate dy after overflow handling.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- PKT_VALID  in  1  packet present on the raw inputs.
- PKT_READY  out  1  tracker can accept a packet.
- STATUS_RAW  in  8  PS/2 status byte: [7] Y overflow, [6] X overflow, [5] Y sign, [4] X sign, [3:0] buttons/flags.
- DX_RAW  in  8  X delta low byte.
- DY_RAW  in  8  Y delta low byte.
- DZ_RAW  in  8  Z delta, 8-bit two's complement.
- CENTRE  in  1  recentre command.
- MOUSE_STATUS  out  4  STATUS_RAW[3:0] from the last committed packet.
- MOUSE_X  out  COORD_W  X position.
- MOUSE_Y  out  COORD_W  Y position.
- MOUSE_Z  out  COORD_W  Z position.
- POS_UPDATED  out  1  one-cycle pulse when positions commit.

Behaviour:
- Clocking: single clock CLK; RESET is synchronous and active-high.
- Reset values: state IDLE, MOUSE_X=LIMIT_X/2, MOUSE_Y=LIMIT_Y/2, MOUSE_Z=LIMIT_Z/2, MOUSE_STATUS=0, POS_UPDATED=0, PKT_READY=1. Integer division, so defaults give 320/240/128.
- FSM states are IDLE, EXT and UPD.
- PKT_READY is combinational: 1 only when state is IDLE and CENTRE=0.
- IDLE: on PKT_VALID & PKT_READY at edge k, register all four raw bytes and go to EXT.
- EXT, registered at edge k+1, produces 9-bit signed deltas:
  - X: if overflow bit [6] is set, dx = sign ? -256 : +255; otherwise dx = {sign, DX_RAW}.
  - Y: same rule using bits [7] and [5].
  - Z: dz is the sign-extension of DZ_RAW.
  - If INVERT_Y=1, dy = -dy.
  - Then every delta is shifted left by SENS_SHIFT into a signed intermediate of width COORD_W+6 with no truncation.
- UPD, at edge k+2:
  - new = {0, pos} + delta, computed signed.
  - Clamp mode: new<0 gives 0; new>LIMIT-1 gives LIMIT-1; otherwise new.
  - Wrap mode: first saturate delta to ±(LIMIT-1); new<0 gives new+LIMIT; new>LIMIT-1 gives new-LIMIT; otherwise new. A single correction step is sufficient.
  - At the same edge: MOUSE_STATUS <= STATUS_RAW[3:0], POS_UPDATED <= 1, next state IDLE.
- Timing:
  - POS_UPDATED is high for exactly the one cycle after edge k+2.
  - PKT_READY is 0 in the two cycles after edge k.
  - The next packet can be accepted at edge k+3 at the earliest. Throughput is one packet per 3 cycles.
- PKT_VALID asserted while PKT_READY=0: no capture, no side effects; the source holds the packet.
- CENTRE=1 at any edge, in any state:
  - Positions go to LIMIT/2.
  - MOUSE_STATUS is unchanged.
  - State goes to IDLE and any in-flight packet is discarded.
  - POS_UPDATED is 0 at that edge.
  - CENTRE beats a simultaneous PKT_VALID: no acceptance, because PKT_READY=0.
- RESET during EXT or UPD: same as full reset; the packet is discarded.
- All three axes update in the same cycle. A zero delta still pulses POS_UPDATED and commits status.

Test Plan:
- Reset: assert RESET 2 cycles, then release -> X=320, Y=240, Z=128, STATUS=0, PKT_READY=1, POS_UPDATED=0.
- Basic packet: STATUS_RAW=0x29, DX=0x10, DY=0xF0, DZ=0x01 from reset -> X=336, Y=224, Z=129, STATUS=0x9. POS_UPDATED pulses exactly 2 edges after acceptance. PKT_READY is low 2 cycles. A back-to-back VALID is accepted on the 3rd edge.
- Clamp and overflow:
  - X=630, DX=0x7F -> X=639.
  - STATUS_RAW=0x48 (X overflow, positive) -> X=639.
  - X=5, STATUS_RAW=0x58 (overflow, negative) -> X=0.
  - Y=2, DY=0xF0 with bit5 set -> Y=0.
- Z wrap: Z=250, DZ=0x0A -> Z=4. Z=3, DZ=0xFB -> Z=254.
- Parameter variants:
  - SENS_SHIFT=2: DX=0x03 -> X+12.
  - INVERT_Y=1: DY=0x10 with bit5=0 -> Y-16.
  - MODE_X=1: X=635, DX=0x0A -> X=5.
  - MODE_X=1, X overflow +255 with LIMIT_X=640 -> X+255 mod 640.
- CENTRE:
  - Pulse CENTRE while in EXT -> no POS_UPDATED, positions 320/240/128, PKT_READY=1 next cycle.
  - CENTRE and PKT_VALID at the same edge -> packet not accepted.
  - RESET while in UPD -> all outputs at reset values.
